// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Build option: SEQ_DIVIDER_EARLY_OUT_EN (consumed in seq_divider.sv).
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_W = 4;

    localparam logic [DIV_W-1:0] DIV_ONES    = {DIV_W{1'b1}};
    localparam logic [DIV_W-1:0] DIV_MIN_NEG = {1'b1, {(DIV_W-1){1'b0}}};

endpackage

// File: rtl/div_addsub.sv
// Unsigned trial subtractor a - b computed as a + ~b + 1; borrow is the
// inverted carry-out.
module div_addsub #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
    assign diff   = sum[N-1:0];
    assign borrow = ~sum[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready both sides.
// Build option: SEQ_DIVIDER_EARLY_OUT_EN skips CALC when |divisor| > |dividend|.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an operation
// CALC  | W restoring steps, one quotient bit per cycle
// DONE  | out_valid=1, result held until out_ready
module seq_divider
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = $clog2(W+1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         is_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero,
    output logic         overflow
);

    localparam logic [W-1:0] ONES    = {W{1'b1}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [W-1:0]       rem_q, rem_n;
    logic [W-1:0]       dvd_q, dvd_n;
    logic [W-1:0]       dvs_q, dvs_n;
    logic               qneg_q, qneg_n;
    logic               rneg_q, rneg_n;
    logic [W-1:0]       quo_q, quo_n;
    logic [W-1:0]       rmd_q, rmd_n;
    logic               dz_q, dz_n;
    logic               ov_q, ov_n;

    logic [W-1:0]       dvd_mag, dvs_mag;
    logic [W:0]         shifted;
    logic [W:0]         diff;
    logic               borrow;
    logic               diff_unused;

    assign dvd_mag = (is_signed && dividend[W-1]) ? -dividend : dividend;
    assign dvs_mag = (is_signed && divisor[W-1])  ? -divisor  : divisor;

    // The partial remainder is always below the divisor, so only W bits are
    // stored; the W+1-bit window is rebuilt each step from the shift.
    assign shifted     = {rem_q, dvd_q[W-1]};
    assign diff_unused = diff[W];

    div_addsub #(.N(W+1)) u_addsub (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            rem_q   <= rem_n;
            dvd_q   <= dvd_n;
            dvs_q   <= dvs_n;
            qneg_q  <= qneg_n;
            rneg_q  <= rneg_n;
            quo_q   <= quo_n;
            rmd_q   <= rmd_n;
            dz_q    <= dz_n;
            ov_q    <= ov_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        rem_n   = rem_q;
        dvd_n   = dvd_q;
        dvs_n   = dvs_q;
        qneg_n  = qneg_q;
        rneg_n  = rneg_q;
        quo_n   = quo_q;
        rmd_n   = rmd_q;
        dz_n    = dz_q;
        ov_n    = ov_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dz_n = 1'b0;
                    ov_n = 1'b0;
                    if (divisor == '0) begin
                        quo_n   = ONES;
                        rmd_n   = dividend;
                        dz_n    = 1'b1;
                        state_n = DONE;
                    end else if (is_signed && dividend == MIN_NEG && divisor == ONES) begin
                        quo_n   = dividend;
                        rmd_n   = '0;
                        ov_n    = 1'b1;
                        state_n = DONE;
`ifdef SEQ_DIVIDER_EARLY_OUT_EN
                    end else if (dvs_mag > dvd_mag) begin
                        quo_n   = '0;
                        rmd_n   = dividend;
                        state_n = DONE;
`endif
                    end else begin
                        dvd_n   = dvd_mag;
                        dvs_n   = dvs_mag;
                        rem_n   = '0;
                        qneg_n  = is_signed && (dividend[W-1] ^ divisor[W-1]);
                        rneg_n  = is_signed && dividend[W-1];
                        cnt_n   = CNT_W'(W);
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                rem_n = borrow ? shifted[W-1:0] : diff[W-1:0];
                dvd_n = {dvd_q[W-2:0], ~borrow};
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quo_n   = qneg_q ? -dvd_n : dvd_n;
                    rmd_n   = rneg_q ? -rem_n : rem_n;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (W=4), hand-computed vectors.
module tb_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       is_signed;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic       overflow;

    int vectors;
    int miscompares;

    seq_divider #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one op at the current time (just after an edge), counts edges
    // from the accepting edge until out_valid is seen; -1 on timeout.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic s,
                         output int cycles);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        cycles    = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        dividend = '0; divisor = '0; is_signed = 1'b0;
        #12;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 4'h0 ||
            remainder !== 4'h0 || div_zero !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: ov=%b ir=%b q=%h r=%h dz=%b of=%b, want 0 1 0 0 0 0",
                     out_valid, in_ready, quotient, remainder, div_zero, overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int c;
        issue(4'd13, 4'd3, 1'b0, c);
        vectors++;
        if (c !== 5) begin
            miscompares++; $display("FAIL u13_3_latency: got %0d want 5", c);
        end
        vectors++;
        if (quotient !== 4'h4 || remainder !== 4'h1 || div_zero !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL u13_3_result: q=%h r=%h dz=%b of=%b want 4 1 0 0",
                     quotient, remainder, div_zero, overflow);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL u13_3_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_signed();
        int c;
        issue(4'b1001, 4'b0010, 1'b1, c);
        vectors++;
        if (c !== 5 || quotient !== 4'b1101 || remainder !== 4'b1111) begin
            miscompares++;
            $display("FAIL s_m7_2: lat=%0d q=%b r=%b want 5 1101 1111", c, quotient, remainder);
        end
        @(posedge clk); #1;
        issue(4'b0111, 4'b1110, 1'b1, c);
        vectors++;
        if (c !== 5 || quotient !== 4'b1101 || remainder !== 4'b0001) begin
            miscompares++;
            $display("FAIL s_7_m2: lat=%0d q=%b r=%b want 5 1101 0001", c, quotient, remainder);
        end
        @(posedge clk); #1;
        // same bit pattern read unsigned: 9/14 = 0 r 9
        issue(4'b1001, 4'b1110, 1'b0, c);
        vectors++;
        if (c < 1 || quotient !== 4'h0 || remainder !== 4'h9 || div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL u9_14: lat=%0d q=%h r=%h dz=%b want 0 9 0", c, quotient, remainder, div_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int c;
        issue(4'd9, 4'd0, 1'b0, c);
        vectors++;
        if (c !== 1) begin
            miscompares++; $display("FAIL div0_latency: got %0d want 1", c);
        end
        vectors++;
        if (quotient !== 4'hF || remainder !== 4'h9 || div_zero !== 1'b1 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL div0_result: q=%h r=%h dz=%b of=%b want F 9 1 0",
                     quotient, remainder, div_zero, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int c;
        issue(4'h8, 4'hF, 1'b1, c);
        vectors++;
        if (c !== 1) begin
            miscompares++; $display("FAIL ovf_latency: got %0d want 1", c);
        end
        vectors++;
        if (quotient !== 4'h8 || remainder !== 4'h0 || overflow !== 1'b1 || div_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_result: q=%h r=%h of=%b dz=%b want 8 0 1 0",
                     quotient, remainder, overflow, div_zero);
        end
        @(posedge clk); #1;
        // -8/1 signed is an ordinary op: -8 r 0, no flags
        issue(4'h8, 4'h1, 1'b1, c);
        vectors++;
        if (c !== 5 || quotient !== 4'h8 || remainder !== 4'h0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL s_m8_1: lat=%0d q=%h r=%h of=%b want 5 8 0 0", c, quotient, remainder, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int c;
        out_ready = 1'b0;
        issue(4'd12, 4'd5, 1'b0, c);
        vectors++;
        if (c !== 5) begin
            miscompares++; $display("FAIL bp_latency: got %0d want 5", c);
        end
        for (int i = 0; i < 3; i++) begin
            dividend = 4'd7; divisor = 4'd1; in_valid = 1'b1;
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 4'd2 || remainder !== 4'd2) begin
                miscompares++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b q=%h r=%h want 1 0 2 2",
                         i, out_valid, in_ready, quotient, remainder);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 4'd2 || remainder !== 4'd2) begin
            miscompares++;
            $display("FAIL bp_release: ov=%b ir=%b q=%h r=%h want 0 1 2 2",
                     out_valid, in_ready, quotient, remainder);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL bp_no_second: ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int c;
        bit seen;
        dividend = 4'd13; divisor = 4'd3; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 4'h0 ||
            remainder !== 4'h0 || div_zero !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: ov=%b ir=%b q=%h r=%h dz=%b of=%b want 0 1 0 0 0 0",
                     out_valid, in_ready, quotient, remainder, div_zero, overflow);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_discard: stray_valid=%b ir=%b want 0 1", seen, in_ready);
        end
        issue(4'd15, 4'd4, 1'b0, c);
        vectors++;
        if (c !== 5 || quotient !== 4'd3 || remainder !== 4'd3) begin
            miscompares++;
            $display("FAIL rst_after: lat=%0d q=%h r=%h want 5 3 3", c, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle W-bit integer divider: restoring algorithm, one quotient bit per clock.
- Sits beside the combinational ALU in the NPC execute stage; services DIV/DIVU/REM/REMU.
- Valid/ready on both input and output; one operation in flight.
- Each restoring step is an unsigned trial subtraction of the divisor from the partial remainder, done in a dedicated add/sub sub-module.

Parameters:
- W, 4, operand/result width in bits (W >= 2).
- CNT_W, $clog2(W+1), width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands and op valid.
- in_ready  out  1  divider can accept an operation.
- dividend  in  W  dividend.
- divisor  in  W  divisor.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- quotient  out  W  quotient.
- remainder  out  W  remainder.
- div_zero  out  1  divisor was zero.
- overflow  out  1  signed most-negative / -1.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; out_valid=0; quotient, remainder, div_zero, overflow = 0; in_ready=1.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid, latch operands and go:
  - divisor==0 -> DONE with quotient = all ones, remainder = dividend, div_zero=1.
  - is_signed, dividend = 1 followed by W-1 zeros, divisor = all ones -> DONE with quotient = dividend, remainder=0, overflow=1.
  - otherwise -> CALC. Capture magnitudes (abs values when is_signed), the two sign bits and is_signed; counter = W.
- CALC: in_ready=0.
  - Each cycle: shift {partial_rem, dividend_mag} left by 1, trial-subtract divisor_mag from the upper W+1 bits.
  - Borrow clear -> keep the difference, quotient bit 1. Otherwise restore, quotient bit 0.
  - Counter decrements. When counter reaches 1 and that step completes, go DONE.
  - Exactly W CALC cycles.
- DONE: out_valid=1; outputs stable until out_ready.
  - Signed fix-up is applied when entering DONE: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Invariant: dividend = quotient*divisor + remainder (mod 2^W).
  - out_valid && out_ready -> IDLE; out_valid drops next cycle. No same-cycle re-accept (in_ready=0 in DONE).
- Latency, accepting edge to out_valid visible:
  - W+1 cycles for normal ops.
  - 1 cycle for div-by-zero and overflow.
- Flags: div_zero and overflow are mutually exclusive and valid only while out_valid=1; both are 0 for normal results.
- in_valid in CALC/DONE is ignored; operand inputs are not sampled.
- Async reset mid-CALC or mid-DONE: immediate return to reset values. The pending result is discarded and never emitted.
- Widths: partial remainder is W+1 bits internally. Magnitude of the most-negative value is held as W-bit unsigned (no loss).

Optional Feature:
- Macro: SEQ_DIVIDER_EARLY_OUT_EN.
- Defined: in IDLE, if divisor_mag > dividend_mag for a nonzero divisor, go straight to DONE. Result is quotient=0, remainder=dividend (original signed value); latency 1 cycle.
- Undefined: every nonzero-divisor, non-overflow op takes the full W-cycle CALC. Results are identical either way; only latency differs.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - default W.
  - localparams for the all-ones quotient and the most-negative pattern (functions of W).
- Sub-module div_addsub:
  - parameterized (W+1)-bit subtractor, A + ~B + 1.
  - outputs difference and borrow.
  - used once per CALC step.

Test Plan:
- Unsigned 13/3, W=4: in_valid 1 cycle, out_ready=1 -> out_valid exactly 5 cycles after accept; quotient=4'h4, remainder=4'h1, flags 0.
- Signed -7/2 (4'b1001 / 4'b0010) -> quotient=4'b1101 (-3), remainder=4'b1111 (-1); signed 7/-2 -> quotient=4'b1101, remainder=4'b0001.
- 9/0 unsigned -> out_valid 1 cycle after accept; quotient=4'hF, remainder=4'h9, div_zero=1, overflow=0.
- Signed -8/-1 (4'h8 / 4'hF) -> 1-cycle result; quotient=4'h8, remainder=4'h0, overflow=1.
- Backpressure, 12/5 with out_ready low 3 cycles after out_valid:
  - outputs hold quotient=2, remainder=2; in_ready stays 0.
  - a second in_valid during this window is ignored.
  - out_ready high -> IDLE next cycle, in_ready=1.
- Reset mid-op: rst_n low during the 2nd CALC cycle -> out_valid=0 and outputs zero immediately; after release, in_ready=1, a new 15/4 yields quotient=3, remainder=3.
